// File: rtl/bcd_serial_adder_ctrl.sv
// ============================================================================
// Module   : bcd_serial_adder_ctrl
// Brief    : Digit-serial packed-BCD adder sequencer. Optional BCD_SUB_EN adds
//            ten's-complement subtraction (Sub/Borrow ports).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
`ifdef BCD_SUB_EN
  input  logic                  Sub,
  output logic                  Borrow,
`endif
  output logic [4*DIGITS+3:0]   Sum,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Invalid
);

  localparam int OPW   = 4 * DIGITS;
  localparam int SUMW  = OPW + 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OPW-1:0]    a_q, a_d, b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUMW-1:0]   sum_q, sum_d;
  logic              invalid_q, invalid_d;

  logic              req_sub;  // subtract request at the Start edge
  logic              op_sub;   // subtract flag of the operation in flight
  logic [3:0]        b_dig;
  logic [4:0]        t;
  logic              carry_out;
  logic [3:0]        digit;

`ifdef BCD_SUB_EN
  logic              sub_q, sub_d, borrow_q, borrow_d;
  assign req_sub = Sub;
  assign op_sub  = sub_q;
  assign Borrow  = borrow_q;
`else
  assign req_sub = 1'b0;
  assign op_sub  = 1'b0;
`endif

  function automatic logic has_bad_digit(input logic [OPW-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    invalid_d = invalid_q;
`ifdef BCD_SUB_EN
    sub_d     = sub_q;
    borrow_d  = borrow_q;
`endif

    // Nine's complement wraps to 4 bits for non-BCD b digits.
    b_dig     = op_sub ? (4'd9 - b_q[3:0]) : b_q[3:0];
    t         = {1'b0, a_q[3:0]} + {1'b0, b_dig} + {4'b0000, carry_q};
    carry_out = (t > 5'd9);
    digit     = carry_out ? (t[3:0] + 4'd6) : t[3:0];

    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d       = A;
          b_d       = B;
          carry_d   = req_sub;
          idx_d     = '0;
          sum_d     = '0;
          invalid_d = has_bad_digit(A) | has_bad_digit(B);
`ifdef BCD_SUB_EN
          sub_d     = Sub;
          borrow_d  = 1'b0;
`endif
          state_d   = ADD;
        end
      end
      ADD: begin
        a_d                      = a_q >> 4;
        b_d                      = b_q >> 4;
        sum_d[int'(idx_q)*4 +: 4] = digit;
        carry_d                  = carry_out;
        idx_d                    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d[SUMW-1 -: 4] = {3'b000, carry_out & ~op_sub};
`ifdef BCD_SUB_EN
          borrow_d           = sub_q & ~carry_out;
`endif
          idx_d              = '0;
          state_d            = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      invalid_q <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q     <= 1'b0;
      borrow_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      invalid_q <= invalid_d;
`ifdef BCD_SUB_EN
      sub_q     <= sub_d;
      borrow_q  <= borrow_d;
`endif
    end
  end

  assign Sum     = sum_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign Invalid = invalid_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_adder_ctrl.sv
// ============================================================================
// Module   : tb_bcd_serial_adder_ctrl
// Brief    : Randomized scoreboard bench for bcd_serial_adder_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_adder_ctrl;

  localparam int D   = 4;
  localparam int OPW = 4 * D;
  localparam int SW  = OPW + 4;
`ifdef BCD_SUB_EN
  localparam bit SUB_BUILD = 1'b1;
`else
  localparam bit SUB_BUILD = 1'b0;
`endif

  logic           Clk   = 1'b0;
  logic           Reset = 1'b1;
  logic           Start = 1'b0;
  logic [OPW-1:0] A     = '0;
  logic [OPW-1:0] B     = '0;
  logic           Sub   = 1'b0;
  logic [SW-1:0]  Sum;
  logic           Busy, Done, Invalid;
`ifdef BCD_SUB_EN
  logic           Borrow;
`endif

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .A       (A),
    .B       (B),
`ifdef BCD_SUB_EN
    .Sub     (Sub),
    .Borrow  (Borrow),
`endif
    .Sum     (Sum),
    .Busy    (Busy),
    .Done    (Done),
    .Invalid (Invalid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [SW-1:0] sum;
    logic          inv;
    logic          brw;
    int            cyc;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   left     = 0;
  exp_t q[$];
  logic [SW-1:0] hold_sum = '0;
  logic          hold_inv = 1'b0;
  logic          hold_brw = 1'b0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Decimal digit-by-digit reference, including the defined behaviour for non-BCD digits.
  function automatic exp_t model(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic s);
    exp_t e;
    int   c, da, db, t;
    e.sum = '0;
    e.cyc = 0;
    e.inv = 1'b0;
    c     = s ? 1 : 0;
    for (int i = 0; i < D; i++) begin
      da = int'((a >> (4*i)) & OPW'(15));
      db = int'((b >> (4*i)) & OPW'(15));
      if (da > 9 || db > 9) e.inv = 1'b1;
      if (s) db = (9 - db) & 15;
      t = da + db + c;
      if (t > 9) begin
        t = (t + 6) % 16;
        c = 1;
      end else begin
        c = 0;
      end
      e.sum = e.sum | (SW'(t) << (4*i));
    end
    if (!s) e.sum = e.sum | (SW'(c) << (4*D));
    e.brw = s && (c == 0);
    return e;
  endfunction

  function automatic logic [OPW-1:0] rand_operand();
    logic [OPW-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) begin
      if ($urandom_range(0, 7) == 0) v = v | (OPW'($urandom_range(0, 15)) << (4*i));
      else                           v = v | (OPW'($urandom_range(0, 9)) << (4*i));
    end
    return v;
  endfunction

  // Predictor: tracks acceptance from the protocol rules and queues expected results.
  exp_t cur_exp;
  always @(posedge Clk) begin
    exp_t e;
    cyc++;
    if (Reset) begin
      left     = 0;
      hold_sum = '0;
      hold_inv = 1'b0;
      hold_brw = 1'b0;
    end else if (left == 0) begin
      if (Start) begin
        e       = model(A, B, Sub & SUB_BUILD);
        e.cyc   = cyc;
        cur_exp = e;
        q.push_back(e);
        left    = D + 1;
      end
    end else begin
      left--;
      if (left == 0) begin
        hold_sum = cur_exp.sum;
        hold_inv = cur_exp.inv;
        hold_brw = cur_exp.brw;
      end
    end
  end

  // Monitor: compares DUT behaviour away from the active edge.
  always @(negedge Clk) begin
    exp_t e;
    if (cyc > 0) begin
      check("busy", SW'(Busy), SW'(left != 0));
      check("done", SW'(Done), SW'(left == 1));
      if (Done) begin
        while (q.size() > 0 && q[0].cyc + D < cyc) void'(q.pop_front());
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: got Done=1, expected no result pending (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("sum",     Sum,              e.sum);
          check("invalid", SW'(Invalid),     SW'(e.inv));
          check("latency", SW'(cyc - e.cyc), SW'(D));
`ifdef BCD_SUB_EN
          check("borrow",  SW'(Borrow),      SW'(e.brw));
`endif
        end
      end
      if (left == 0) begin
        check("sum_hold",     Sum,          hold_sum);
        check("invalid_hold", SW'(Invalid), SW'(hold_inv));
`ifdef BCD_SUB_EN
        check("borrow_hold",  SW'(Borrow),  SW'(hold_brw));
`endif
      end
    end
  end

  task automatic do_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic s);
    @(negedge Clk);
    A = a; B = b; Sub = s; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    A = OPW'($urandom); B = OPW'($urandom); Sub = 1'($urandom);
    repeat (D + 1) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_sum",     Sum,          '0);
    check("rst_busy",    SW'(Busy),    '0);
    check("rst_done",    SW'(Done),    '0);
    check("rst_invalid", SW'(Invalid), '0);
    Reset = 1'b0;

    do_op(16'h1234, 16'h5678, 1'b0);
    check("add_1234_5678", Sum, 20'h06912);
    check("add_1234_inv",  SW'(Invalid), '0);
    do_op(16'h9999, 16'h0001, 1'b0);
    check("add_ripple", Sum, 20'h10000);
    do_op(16'h0000, 16'h0000, 1'b0);
    check("add_zero", Sum, 20'h00000);
    do_op(16'h00A0, 16'h0000, 1'b0);
    check("add_bad_digit", Sum, 20'h00100);
    check("bad_digit_inv", SW'(Invalid), SW'(1'b1));

    // Start held high with operands changing every cycle.
    @(negedge Clk);
    Start = 1'b1;
    repeat (3 * (D + 2) + 1) begin
      A = rand_operand(); B = rand_operand();
      @(negedge Clk);
    end
    Start = 1'b0;
    repeat (D + 2) @(negedge Clk);

    // Reset during the second ADD cycle aborts the operation.
    A = 16'h4321; B = 16'h1111; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_busy", SW'(Busy), '0);
    check("abort_sum",  Sum,       '0);
    check("abort_done", SW'(Done), '0);
    repeat (D + 2) @(negedge Clk);
    do_op(16'h0555, 16'h0445, 1'b0);
    check("after_abort", Sum, 20'h01000);

`ifdef BCD_SUB_EN
    do_op(16'h5000, 16'h1234, 1'b1);
    check("sub_pos",     Sum,         20'h03766);
    check("sub_pos_brw", SW'(Borrow), '0);
    do_op(16'h1234, 16'h5000, 1'b1);
    check("sub_neg",     Sum,         20'h06234);
    check("sub_neg_brw", SW'(Borrow), SW'(1'b1));
`endif

    for (int i = 0; i < 40; i++) begin
      do_op(rand_operand(), rand_operand(), 1'($urandom) & SUB_BUILD);
    end

    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
